// File: rtl/evict_write_buffer.sv
// evict_write_buffer
// Line-granular write buffer sitting between the L1 D-cache memory port and
// the data-side arbiter port. Dirty victims are absorbed in a short handshake
// so the miss fill can go out first. Buffered lines drain whenever the D-side
// is otherwise quiet.
//
// Optional feature macro: EVICT_BUF_FWD_EN
//   defined   : a read whose tag hits a buffered line is answered from the buffer.
//   undefined : such a read first drains the buffer in FIFO order until the
//               matching line has left, then goes downstream like any miss.
module evict_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_read,
    input  logic                       up_write,
    input  logic [31:0]                up_address,
    input  logic [255:0]               up_wdata,
    output logic [255:0]               up_rdata,
    output logic                       up_resp,
    output logic                       dn_read,
    output logic                       dn_write,
    output logic [31:0]                dn_address,
    output logic [255:0]               dn_wdata,
    input  logic [255:0]               dn_rdata,
    input  logic                       dn_resp,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Control and output registers
    logic [1:0]       state_q,     state_d;
    logic             upResp_q,    upResp_d;
    logic [255:0]     upRdata_q,   upRdata_d;
    logic             dnRead_q,    dnRead_d;
    logic             dnWrite_q,   dnWrite_d;
    logic [31:0]      dnAddress_q, dnAddress_d;
    logic [255:0]     dnWdata_q,   dnWdata_d;
    logic [PTR_W-1:0] head_q,      head_d;
    logic [PTR_W-1:0] tail_q,      tail_d;
    logic [OCC_W-1:0] occ_q,       occ_d;

    // Entry storage; valid bits carry the reset, tag/data are plain storage
    logic [DEPTH-1:0] valid_q;
    logic [26:0]      tag_q  [DEPTH];
    logic [255:0]     data_q [DEPTH];

    // Storage write controls produced by the FSM
    logic             wrEn;
    logic             wrAlloc;
    logic [PTR_W-1:0] wrIdx;
    logic             popEn;

    // Tag lookup results
    logic [26:0]      upTag;
    logic             hitAny;
    logic [PTR_W-1:0] hitIdx;
    logic             full;
    logic             unusedAddrBits;

    assign upTag          = up_address[31:5];
    assign unusedAddrBits = ^up_address[4:0];
    assign full           = (occ_q == OCC_W'(DEPTH));

    // Advance a FIFO pointer with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Compare the requested line against every valid entry; coalescing on
    // writes guarantees at most one entry can match
    always_comb begin
        hitAny = 1'b0;
        hitIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == upTag)) begin
                hitAny = 1'b1;
                hitIdx = PTR_W'(i);
            end
        end
    end

    // Next-state logic: IDLE arbitrates read > write > drain, the other states
    // hold their downstream request until the arbiter answers
    always_comb begin
        state_d     = state_q;
        upResp_d    = upResp_q;
        upRdata_d   = upRdata_q;
        dnRead_d    = dnRead_q;
        dnWrite_d   = dnWrite_q;
        dnAddress_d = dnAddress_q;
        dnWdata_d   = dnWdata_q;
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        wrEn        = 1'b0;
        wrAlloc     = 1'b0;
        wrIdx       = tail_q;
        popEn       = 1'b0;

        case (state_q)
            IDLE: begin
                if (up_read) begin
`ifdef EVICT_BUF_FWD_EN
                    if (hitAny) begin
                        upRdata_d = data_q[hitIdx];
                        upResp_d  = 1'b1;
                        state_d   = RESP;
                    end else begin
                        dnRead_d    = 1'b1;
                        dnAddress_d = {upTag, 5'b0};
                        state_d     = READ;
                    end
`else
                    if (hitAny) begin
                        dnWrite_d   = 1'b1;
                        dnAddress_d = {tag_q[head_q], 5'b0};
                        dnWdata_d   = data_q[head_q];
                        state_d     = DRAIN;
                    end else begin
                        dnRead_d    = 1'b1;
                        dnAddress_d = {upTag, 5'b0};
                        state_d     = READ;
                    end
`endif
                end else if (up_write) begin
                    if (hitAny) begin
                        wrEn     = 1'b1;
                        wrIdx    = hitIdx;
                        upResp_d = 1'b1;
                        state_d  = RESP;
                    end else if (!full) begin
                        wrEn     = 1'b1;
                        wrAlloc  = 1'b1;
                        wrIdx    = tail_q;
                        tail_d   = ptrInc(tail_q);
                        occ_d    = occ_q + 1'b1;
                        upResp_d = 1'b1;
                        state_d  = RESP;
                    end else begin
                        dnWrite_d   = 1'b1;
                        dnAddress_d = {tag_q[head_q], 5'b0};
                        dnWdata_d   = data_q[head_q];
                        state_d     = DRAIN;
                    end
                end else if (occ_q != '0) begin
                    dnWrite_d   = 1'b1;
                    dnAddress_d = {tag_q[head_q], 5'b0};
                    dnWdata_d   = data_q[head_q];
                    state_d     = DRAIN;
                end
            end

            READ: begin
                if (dn_resp) begin
                    upRdata_d = dn_rdata;
                    dnRead_d  = 1'b0;
                    upResp_d  = 1'b1;
                    state_d   = RESP;
                end
            end

            DRAIN: begin
                if (dn_resp) begin
                    popEn     = 1'b1;
                    head_d    = ptrInc(head_q);
                    occ_d     = occ_q - 1'b1;
                    dnWrite_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            RESP: begin
                upResp_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any downstream transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            upResp_q    <= 1'b0;
            upRdata_q   <= '0;
            dnRead_q    <= 1'b0;
            dnWrite_q   <= 1'b0;
            dnAddress_q <= '0;
            dnWdata_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            upResp_q    <= upResp_d;
            upRdata_q   <= upRdata_d;
            dnRead_q    <= dnRead_d;
            dnWrite_q   <= dnWrite_d;
            dnAddress_q <= dnAddress_d;
            dnWdata_q   <= dnWdata_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
        end
    end

    // Valid bits: set on allocation, cleared when the head line drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (wrAlloc) begin
                valid_q[wrIdx] <= 1'b1;
            end
            if (popEn) begin
                valid_q[head_q] <= 1'b0;
            end
        end
    end

    // Tag and data storage; contents only matter while the valid bit is set
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tag_q[wrIdx]  <= upTag;
            data_q[wrIdx] <= up_wdata;
        end
    end

    assign up_rdata   = upRdata_q;
    assign up_resp    = upResp_q;
    assign dn_read    = dnRead_q;
    assign dn_write   = dnWrite_q;
    assign dn_address = dnAddress_q;
    assign dn_wdata   = dnWdata_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_evict_write_buffer.sv
// tb_evict_write_buffer
// Directed self-checking bench for evict_write_buffer with DEPTH=2.
// Inputs change 1 time unit after a rising edge and outputs are sampled there.
module tb_evict_write_buffer;

    localparam int DEPTH = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       up_read;
    logic                       up_write;
    logic [31:0]                up_address;
    logic [255:0]               up_wdata;
    logic [255:0]               up_rdata;
    logic                       up_resp;
    logic                       dn_read;
    logic                       dn_write;
    logic [31:0]                dn_address;
    logic [255:0]               dn_wdata;
    logic [255:0]               dn_rdata;
    logic                       dn_resp;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int lat;

    localparam logic [255:0] DATA_A = {8{32'hAAAA_0001}};
    localparam logic [255:0] DATA_P = {8{32'h1111_0100}};
    localparam logic [255:0] DATA_Q = {8{32'h2222_0200}};
    localparam logic [255:0] DATA_R = {8{32'h3333_0300}};
    localparam logic [255:0] DATA_B = {8{32'hBBBB_0400}};
    localparam logic [255:0] DATA_E = {8{32'hEEEE_0404}};
    localparam logic [255:0] DATA_C = {8{32'hCCCC_0500}};
    localparam logic [255:0] DATA_D = {8{32'hDDDD_0500}};
    localparam logic [255:0] DATA_F = {8{32'hF0F0_0700}};
    localparam logic [255:0] DATA_G = {8{32'h6060_0600}};
    localparam logic [255:0] DATA_H = {8{32'h8080_0800}};
    localparam logic [255:0] DATA_J = {8{32'h9090_0900}};

    evict_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_read    (up_read),
        .up_write   (up_write),
        .up_address (up_address),
        .up_wdata   (up_wdata),
        .up_rdata   (up_rdata),
        .up_resp    (up_resp),
        .dn_read    (dn_read),
        .dn_write   (dn_write),
        .dn_address (dn_address),
        .dn_wdata   (dn_wdata),
        .dn_rdata   (dn_rdata),
        .dn_resp    (dn_resp),
        .occupancy  (occupancy)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] wdata);
        up_read    = rd;
        up_write   = wr;
        up_address = addr;
        up_wdata   = wdata;
    endtask

    // Holds an up request until up_resp and returns the cycles it took (0 on timeout)
    task automatic upRequest(input logic isWrite, input logic [31:0] addr, input logic [255:0] wdata, output int latency);
        applyStimulus(!isWrite, isWrite, addr, wdata);
        latency = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (up_resp === 1'b1) begin
                latency = i;
                break;
            end
        end
        applyStimulus(1'b0, 1'b0, addr, wdata);
    endtask

    // Waits for a drain write, checks it, and answers it with one dn_resp pulse
    task automatic drainOne(input string tag, input logic [31:0] expAddr, input logic [255:0] expData);
        int waited = 0;
        while (dn_write !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput({tag, " dn_write"}, 256'(dn_write), 256'(1));
        checkOutput({tag, " dn_address"}, 256'(dn_address), 256'(expAddr));
        checkOutput({tag, " dn_wdata"}, dn_wdata, expData);
        checkOutput({tag, " dn_read idle"}, 256'(dn_read), 256'(0));
        dn_resp = 1'b1;
        tick();
        dn_resp = 1'b0;
        checkOutput({tag, " dn_write drop"}, 256'(dn_write), 256'(0));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " up_resp"}, 256'(up_resp), 256'(0));
        checkOutput({tag, " up_rdata"}, up_rdata, 256'(0));
        checkOutput({tag, " dn_read"}, 256'(dn_read), 256'(0));
        checkOutput({tag, " dn_write"}, 256'(dn_write), 256'(0));
        checkOutput({tag, " dn_address"}, 256'(dn_address), 256'(0));
        checkOutput({tag, " dn_wdata"}, dn_wdata, 256'(0));
        checkOutput({tag, " occupancy"}, 256'(occupancy), 256'(0));
    endtask

    initial begin
        rst      = 1'b1;
        dn_rdata = '0;
        dn_resp  = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        tick();
        tick();
        checkResetOutputs("reset");
        rst = 1'b0;
        tick();

        // Single write, then an automatic drain on the next idle cycle
        $display("[TB] single write and drain");
        upRequest(1'b1, 32'h0000_1020, DATA_A, lat);
        checkOutput("wrA latency", 256'(lat), 256'(1));
        checkOutput("wrA occupancy", 256'(occupancy), 256'(1));
        tick();
        checkOutput("wrA resp drop", 256'(up_resp), 256'(0));
        checkOutput("wrA no early drain", 256'(dn_write), 256'(0));
        tick();
        checkOutput("wrA drain start", 256'(dn_write), 256'(1));
        drainOne("drainA", 32'h0000_1020, DATA_A);
        checkOutput("drainA occupancy", 256'(occupancy), 256'(0));
        tick();
        checkOutput("empty stays idle", 256'(dn_write), 256'(0));

        // Fill the buffer, third write stalls behind a forced drain
        $display("[TB] full buffer stall");
        upRequest(1'b1, 32'h0000_0100, DATA_P, lat);
        checkOutput("wr100 latency", 256'(lat), 256'(1));
        upRequest(1'b1, 32'h0000_0200, DATA_Q, lat);
        checkOutput("wr200 latency", 256'(lat), 256'(2));
        checkOutput("full occupancy", 256'(occupancy), 256'(2));
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, DATA_R);
        tick();
        tick();
        checkOutput("stall dn_write", 256'(dn_write), 256'(1));
        checkOutput("stall dn_address", 256'(dn_address), 256'(32'h0000_0100));
        checkOutput("stall dn_wdata", dn_wdata, DATA_P);
        tick();
        tick();
        tick();
        checkOutput("stall held address", 256'(dn_address), 256'(32'h0000_0100));
        checkOutput("stall no up_resp", 256'(up_resp), 256'(0));
        checkOutput("stall occupancy", 256'(occupancy), 256'(2));
        dn_resp = 1'b1;
        tick();
        dn_resp = 1'b0;
        checkOutput("pop occupancy", 256'(occupancy), 256'(1));
        checkOutput("pop dn_write drop", 256'(dn_write), 256'(0));
        tick();
        checkOutput("wr300 accepted", 256'(up_resp), 256'(1));
        checkOutput("wr300 occupancy", 256'(occupancy), 256'(2));
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        drainOne("drain200", 32'h0000_0200, DATA_Q);
        drainOne("drain300", 32'h0000_0300, DATA_R);
        checkOutput("after fill occupancy", 256'(occupancy), 256'(0));

        // Read of a buffered line
        $display("[TB] read of buffered line");
        upRequest(1'b1, 32'h0000_0400, DATA_B, lat);
        checkOutput("wr400 latency", 256'(lat), 256'(1));
        applyStimulus(1'b1, 1'b0, 32'h0000_040C, 256'h0);
        tick();
        tick();
`ifdef EVICT_BUF_FWD_EN
        checkOutput("fwd up_resp", 256'(up_resp), 256'(1));
        checkOutput("fwd up_rdata", up_rdata, DATA_B);
        checkOutput("fwd no dn_read", 256'(dn_read), 256'(0));
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        drainOne("drain400", 32'h0000_0400, DATA_B);
`else
        checkOutput("nofwd no up_resp", 256'(up_resp), 256'(0));
        drainOne("drain400", 32'h0000_0400, DATA_B);
        tick();
        checkOutput("nofwd dn_read", 256'(dn_read), 256'(1));
        checkOutput("nofwd dn_address", 256'(dn_address), 256'(32'h0000_0400));
        dn_rdata = DATA_E;
        dn_resp  = 1'b1;
        tick();
        dn_resp  = 1'b0;
        checkOutput("nofwd up_resp", 256'(up_resp), 256'(1));
        checkOutput("nofwd up_rdata", up_rdata, DATA_E);
        checkOutput("nofwd dn_read drop", 256'(dn_read), 256'(0));
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        tick();
`endif
        checkOutput("read400 occupancy", 256'(occupancy), 256'(0));

        // Coalescing writes to the same line
        $display("[TB] coalesce");
        upRequest(1'b1, 32'h0000_0500, DATA_C, lat);
        checkOutput("wr500 latency", 256'(lat), 256'(1));
        upRequest(1'b1, 32'h0000_051F, DATA_D, lat);
        checkOutput("wr51F latency", 256'(lat), 256'(2));
        checkOutput("coalesce occupancy", 256'(occupancy), 256'(1));
        drainOne("drain500", 32'h0000_0500, DATA_D);
        checkOutput("coalesce empty", 256'(occupancy), 256'(0));

        // Read miss takes priority over a pending drain
        $display("[TB] read miss before drain");
        upRequest(1'b1, 32'h0000_0700, DATA_F, lat);
        checkOutput("wr700 latency", 256'(lat), 256'(1));
        applyStimulus(1'b1, 1'b0, 32'h0000_0600, 256'h0);
        tick();
        tick();
        checkOutput("miss dn_read", 256'(dn_read), 256'(1));
        checkOutput("miss no dn_write", 256'(dn_write), 256'(0));
        checkOutput("miss dn_address", 256'(dn_address), 256'(32'h0000_0600));
        checkOutput("miss occupancy", 256'(occupancy), 256'(1));
        dn_rdata = DATA_G;
        dn_resp  = 1'b1;
        tick();
        dn_resp  = 1'b0;
        checkOutput("miss up_resp", 256'(up_resp), 256'(1));
        checkOutput("miss up_rdata", up_rdata, DATA_G);
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        drainOne("drain700", 32'h0000_0700, DATA_F);

        // Reset in the middle of a drain with two lines buffered
        $display("[TB] reset during drain");
        upRequest(1'b1, 32'h0000_0800, DATA_H, lat);
        checkOutput("wr800 latency", 256'(lat), 256'(1));
        upRequest(1'b1, 32'h0000_0900, DATA_J, lat);
        checkOutput("wr900 latency", 256'(lat), 256'(2));
        tick();
        tick();
        checkOutput("pre-reset dn_write", 256'(dn_write), 256'(1));
        checkOutput("pre-reset occupancy", 256'(occupancy), 256'(2));
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("async reset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("post-reset no dn_write", 256'(dn_write), 256'(0));
        checkOutput("post-reset occupancy", 256'(occupancy), 256'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
